// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers, combinational full/empty flags
// and a registered read-data port. Storage is intentionally left unreset.
module asynchronous_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] data_out_r;
  logic             wr_accept_s;
  logic             rd_accept_s;
  logic             full_s;
  logic             empty_s;

  // Flag decode and request qualification from the registered pointers.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                  (wr_ptr_r[AW] != rd_ptr_r[AW]);
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    if (!w_rst) begin
      wr_accept_s = w_en && !full_s;
      rd_accept_s = r_en && !empty_s;
    end else begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
    end
  end

  // Write pointer: wraps modulo 2*DEPTH via natural overflow of the extra bit.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
    end else if (wr_accept_s) begin
      wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Read pointer and registered read data; data_out holds on rejected reads.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rd_ptr_r   <= {(AW+1){1'b0}};
      data_out_r <= {WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_ptr_r   <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      data_out_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Storage array, written only on an accepted write.
  always_ff @(posedge w_clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_r;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed plus randomized bench for asynchronous_fifo, checked against a
// queue-based occupancy model held in the bench.
module tb_asynchronous_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             w_clk;
  logic             w_rst;
  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int n_assert;
  int n_fail;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout;

  asynchronous_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_en    (w_en),
    .r_en    (r_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_dout"},  32'(data_out), 32'(model_dout));
    chk({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Drive one cycle of requests, advance the model at the edge, check at negedge.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
    bit was_full;
    bit was_empty;
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge w_clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (r && !was_empty) model_dout = model_q.pop_front();
    if (w && !was_full)  model_q.push_back(d);
    @(negedge w_clk);
    chk_all(tag);
  endtask

  task automatic apply_reset_pulse(input string tag);
    #2;
    w_rst = 1'b1;
    #1;
    model_q.delete();
    model_dout = '0;
    chk_all(tag);
    #2;
    w_rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    n_assert   = 0;
    n_fail     = 0;
    model_dout = '0;
    w_rst      = 1'b0;
    w_en       = 1'b0;
    r_en       = 1'b0;
    data_in    = '0;

    #1 w_rst = 1'b1;
    #1 chk_all("reset_async");
    w_en = 1'b1;
    data_in = 8'hEE;
    @(negedge w_clk);
    chk_all("reset_held");
    w_en = 1'b0;
    w_rst = 1'b0;

    // Fill, overfill, drain, overdrain.
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i * 17);
      step(1'b1, 1'b0, v, "fill");
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'h99, "overfill");
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain");
      chk("drain_order", 32'(data_out), 32'(i * 17));
    end
    step(1'b0, 1'b1, 8'h00, "overdrain");
    chk("overdrain_hold", 32'(data_out), 32'h88);

    // Wrap-around.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "wrap_w5");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "wrap_r5");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "wrap_fill");
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, "wrap_drain");
      chk("wrap_order", 32'(data_out), 32'(8'hA0 + i));
    end

    // Simultaneous access at mid occupancy, full and empty.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "sim_pre");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), "sim_both");
    chk("sim_occ", 32'(model_q.size()), 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "sim_tofull");
    step(1'b1, 1'b1, 8'h3C, "sim_full_both");
    chk("sim_full_after", 32'(full), 32'd0);
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, "sim_drain");
    v = model_dout;
    step(1'b1, 1'b1, 8'hC3, "sim_empty_both");
    chk("sim_empty_hold", 32'(data_out), 32'(v));
    step(1'b0, 1'b1, 8'h00, "sim_empty_rd");
    chk("sim_empty_rd_val", 32'(data_out), 32'hC3);

    // Reset mid-operation.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "mid_pre");
    w_en = 1'b0;
    apply_reset_pulse("mid_reset");
    @(negedge w_clk);
    chk_all("mid_after");
    step(1'b1, 1'b0, 8'h5A, "mid_w");
    step(1'b0, 1'b1, 8'h00, "mid_r");
    chk("mid_5a", 32'(data_out), 32'h5A);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
